batt_monitor: RTL



---
 rtl/batt_pkg.sv | 38 +++
 rtl/batt_avg4.sv | 41 ++++
 rtl/batt_monitor.sv | 137 +++++++++++++
 3 files changed

// File: rtl/batt_pkg.sv
// ============================================================================
// Module      : batt_pkg
// Description : Shared FSM state type, threshold defaults and LED helpers
//               for the battery monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package batt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACCUM = 2'd3
    } batt_state_t;

    localparam logic [7:0] C_LOW_TH_DEF = 8'hB0;
    localparam logic [7:0] C_HYST_DEF   = 8'h08;

    // Exit threshold is formed in 9 bits so LOW_TH+HYST cannot wrap.
    function automatic logic [7:0] exit_th(input logic [7:0] low_th,
                                           input logic [7:0] hyst);
        logic [8:0] s;
        s = {1'b0, low_th} + {1'b0, hyst};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    // avg[7:5]+1 LEDs lit from bit 0 upward.
    function automatic logic [7:0] therm8(input logic [7:0] avg);
        logic [7:0] mask;
        mask = 8'hFE << avg[7:5];
        return ~mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/batt_avg4.sv
// ============================================================================
// Module      : batt_avg4
// Description : 4-entry sample shift register with first-sample priming and
//               a 10-bit running sum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module batt_avg4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [7:0] i_sample,
    output logic [9:0] o_sum,
    output logic       o_primed
);

    logic [3:0][7:0] r_smp;
    logic            r_primed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_smp    <= '0;
            r_primed <= 1'b0;
        end else if (i_load) begin
            if (!r_primed) begin
                // Fill every slot so the first average is the sample itself.
                r_smp    <= {4{i_sample}};
                r_primed <= 1'b1;
            end else begin
                r_smp <= {r_smp[2:0], i_sample};
            end
        end
    end

    assign o_sum    = 10'(r_smp[0]) + 10'(r_smp[1]) + 10'(r_smp[2]) + 10'(r_smp[3]);
    assign o_primed = r_primed;

endmodule

`default_nettype wire

// File: rtl/batt_monitor.sv
// ============================================================================
// Module      : batt_monitor
// Description : Periodic battery A2D sampler with running average,
//               hysteretic low-battery flag and LED bar/blink output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module batt_monitor
    import batt_pkg::*;
#(
    parameter int         PER_W  = 20,
    parameter int         TO_W   = 10,
    parameter logic [7:0] LOW_TH = C_LOW_TH_DEF,
    parameter logic [7:0] HYST   = C_HYST_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cnv_cmplt,
    input  logic [11:0] res,
    output logic        strt_cnv,
    output logic [7:0]  batt,
    output logic        batt_vld,
    output logic        batt_low,
    output logic [7:0]  led,
    output logic        a2d_err
);

    localparam logic [7:0] c_exit_th = exit_th(LOW_TH, HYST);

    batt_state_t     r_state;
    logic [PER_W-1:0] r_per_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic             r_strt_cnv;
    logic [7:0]       r_batt;
    logic             r_batt_low;
    logic [7:0]       r_led;
    logic             r_a2d_err;

    logic             w_tick;
    logic [TO_W-1:0]  w_to_next;
    logic             w_timeout;
    logic             w_capture;
    logic [9:0]       w_sum;
    logic [7:0]       w_avg;
    logic             w_low_next;
    logic [7:0]       w_blink;
    logic             w_unused;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_per_cnt <= '0;
        else        r_per_cnt <= r_per_cnt + PER_W'(1);
    end

    assign w_tick    = &r_per_cnt;
    assign w_to_next = r_to_cnt + TO_W'(1);
    assign w_timeout = (w_to_next == {TO_W{1'b1}});
    assign w_capture = (r_state == ST_WAIT) && cnv_cmplt;

    batt_avg4 u_avg4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_capture),
        .i_sample (res[11:4]),
        .o_sum    (w_sum),
        .o_primed (batt_vld)
    );

    assign w_avg   = w_sum[9:2];
    assign w_blink = {8{r_per_cnt[PER_W-1]}};

    always_comb begin
        w_low_next = r_batt_low;
        if (w_avg < LOW_TH)
            w_low_next = 1'b1;
        else if (w_avg >= c_exit_th)
            w_low_next = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_to_cnt   <= '0;
            r_strt_cnv <= 1'b0;
            r_batt     <= '0;
            r_batt_low <= 1'b0;
            r_led      <= '0;
            r_a2d_err  <= 1'b0;
        end else begin
            r_strt_cnv <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        r_state    <= ST_START;
                        r_strt_cnv <= 1'b1;
                    end
                end
                ST_START: begin
                    r_state  <= ST_WAIT;
                    r_to_cnt <= '0;
                end
                ST_WAIT: begin
                    // Ticks are not looked at here, so they are dropped.
                    if (cnv_cmplt) begin
                        r_state   <= ST_ACCUM;
                        r_a2d_err <= 1'b0;
                    end else if (w_timeout) begin
                        r_state   <= ST_IDLE;
                        r_a2d_err <= 1'b1;
                    end else begin
                        r_to_cnt <= w_to_next;
                    end
                end
                ST_ACCUM: begin
                    r_state    <= ST_IDLE;
                    r_batt     <= w_avg;
                    r_batt_low <= w_low_next;
                    r_led      <= w_low_next ? w_blink : therm8(w_avg);
                end
                default: r_state <= ST_IDLE;
            endcase
            if ((r_state != ST_ACCUM) && r_batt_low)
                r_led <= w_blink;
        end
    end

    assign strt_cnv = r_strt_cnv;
    assign batt     = r_batt;
    assign batt_low = r_batt_low;
    assign led      = r_led;
    assign a2d_err  = r_a2d_err;

    assign w_unused = ^{res[3:0], w_sum[1:0]};

endmodule

`default_nettype wire
